// File: rtl/lut_fn_pkg.sv
// lut_fn_pkg
//   Shared types and sizing helpers for the LUT function unit.
//   - ld_state_t : table loader states
//   - tbl_w()    : truth-table depth in bits for an N_IN-input function
//   - cnt_w()    : width of a counter that can hold tbl_w()
//   - STAT_W     : width of the per-channel ones counters
package lut_fn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } ld_state_t;

  localparam int STAT_W = 16;

  function automatic int tbl_w(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/lut_fn_loader.sv
// lut_fn_loader
//   Serial truth-table loader. A table is shifted in MSB first into a shadow
//   register; once TBL_W bits have arrived, a one-cycle commit strobe tells
//   the owner of the tables to copy the shadow into channel commit_ch.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_start       begin a load (honoured in IDLE only, cfg_ch < N_CH)
//   cfg_ch          target channel, sampled with cfg_start
//   cfg_bit_valid   cfg_bit carries a table bit (honoured in LOAD only)
//   cfg_bit         serial table bit
//   cfg_busy        loader is in LOAD or COMMIT
//   commit          high for the single COMMIT cycle
//   commit_ch       channel being loaded
//   shadow          assembled table, valid while commit is high
module lut_fn_loader
  import lut_fn_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_CH = 2,
  parameter int CH_W = 1,
  localparam int TBL_W = tbl_w(N_IN),
  localparam int CNT_W = cnt_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_bit_valid,
  input  logic             cfg_bit,
  output logic             cfg_busy,
  output logic             commit,
  output logic [CH_W-1:0]  commit_ch,
  output logic [TBL_W-1:0] shadow
);

  ld_state_t        state;
  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shadow    <= '0;
      commit_ch <= '0;
      commit    <= 1'b0;
      cfg_busy  <= 1'b0;
    end else begin
      commit <= 1'b0;
      unique case (state)
        IDLE: begin
          // Out-of-range channels never leave IDLE, so no table is touched.
          if (cfg_start && (int'(cfg_ch) < N_CH)) begin
            state     <= LOAD;
            commit_ch <= cfg_ch;
            bit_cnt   <= '0;
            cfg_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_bit_valid) begin
            shadow  <= {shadow[TBL_W-2:0], cfg_bit};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(TBL_W - 1)) begin
              state  <= COMMIT;
              commit <= 1'b1;
            end
          end
        end
        COMMIT: begin
          state    <= IDLE;
          cfg_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lut_function_unit.sv
// lut_function_unit
//   Multi-channel programmable Boolean function unit. Channel c looks up
//   in_vec[c*N_IN +: N_IN] in its own TBL_W-bit truth table; results are
//   held in a valid/ready output register (latency 1). Tables are reloaded
//   serially through lut_fn_loader without stalling evaluation.
//   Optional feature macro: LUT_STATS_EN (per-channel saturating ones
//   counters read through stat_ch/stat_count; tied to zero when undefined).
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_vec   input vector handshake
//   out_valid/out_ready/out_y  result handshake, out_y[c] = table_c[in_vec_c]
//   cfg_start/cfg_ch           start a table load for channel cfg_ch
//   cfg_bit_valid/cfg_bit      serial table bits, MSB first
//   cfg_busy                   loader not idle
//   stat_ch/stat_count         ones-counter readout
module lut_function_unit
  import lut_fn_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_CH = 2,
  parameter logic [N_CH*(2**N_IN)-1:0] INIT = {N_CH{8'h31}},
  localparam int TBL_W = tbl_w(N_IN),
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*N_IN-1:0] in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_CH-1:0]      out_y,
  input  logic                 cfg_start,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic                 cfg_bit_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_busy,
  input  logic [CH_W-1:0]      stat_ch,
  output logic [STAT_W-1:0]    stat_count
);

  logic [N_CH*TBL_W-1:0] tbl;
  logic                  commit;
  logic [CH_W-1:0]       commit_ch;
  logic [TBL_W-1:0]      shadow;
  logic                  accept;
  logic [N_CH-1:0]       y_eval;

  lut_fn_loader #(
    .N_IN (N_IN),
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_loader (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_ch        (cfg_ch),
    .cfg_bit_valid (cfg_bit_valid),
    .cfg_bit       (cfg_bit),
    .cfg_busy      (cfg_busy),
    .commit        (commit),
    .commit_ch     (commit_ch),
    .shadow        (shadow)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    y_eval = '0;
    for (int c = 0; c < N_CH; c++)
      y_eval[c] = tbl[c*TBL_W + int'(in_vec[c*N_IN +: N_IN])];
  end

  // Table store: the whole channel table is replaced in the commit cycle,
  // so an accept in that same cycle still sees the previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tbl <= INIT;
    else if (commit)
      tbl[int'(commit_ch)*TBL_W +: TBL_W] <= shadow;
  end

  // ---- output register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_y     <= y_eval;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LUT_STATS_EN
  logic [STAT_W-1:0] stat_cnt [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++)
        stat_cnt[c] <= '0;
    end else if (accept) begin
      for (int c = 0; c < N_CH; c++)
        if (y_eval[c] && (stat_cnt[c] != '1))
          stat_cnt[c] <= stat_cnt[c] + 1'b1;
    end
  end

  assign stat_count = (int'(stat_ch) < N_CH) ? stat_cnt[stat_ch] : '0;
`else
  logic unused_stat_ch;
  assign unused_stat_ch = ^stat_ch;
  assign stat_count     = '0;
`endif

endmodule
